mux_rr_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one N:1 data mux between N_REQ requesters feeding a single sink.
- Grants one requester at a time, drives the mux select, and holds the grant for a multi-beat transfer.
- Releases the grant on last beat, on request drop, or when a hold limit is reached.
- Sits between requester ports and any single-consumer datapath.

---
 rtl/mux_arb_pkg.sv | 35 +++
 rtl/rr_pick.sv | 41 ++++
 rtl/mux_rr_arbiter.sv | 157 +++++++++++++++
 tb/tb_mux_rr_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_arb_pkg.sv
// Shared types, defaults and index helpers for the round-robin mux arbiter.
package mux_arb_pkg;

  // Arbiter sequencing states: IDLE searches for a winner, GRANT owns the mux.
  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  // Reason the current grant ends this cycle, listed in priority order.
  typedef enum logic [1:0] {
    REL_NONE    = 2'd0,
    REL_ABANDON = 2'd1,
    REL_LAST    = 2'd2,
    REL_LIMIT   = 2'd3
  } rel_cause_e;

  // Default parameter set.
  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DATA_W   = 8;
  localparam int DEF_MAX_HOLD = 16;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int sel_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // Cyclic index arithmetic: (base + off) modulo n.
  function automatic int unsigned wrap_idx(input int unsigned base,
                                           input int unsigned off,
                                           input int unsigned n);
    return (base + off) % n;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or after start_idx,
// searching cyclically. Built as rotate -> priority-encode -> unrotate.
module rr_pick
  import mux_arb_pkg::*;
#(
  parameter int N  = DEF_N_REQ,
  parameter int IW = sel_width(DEF_N_REQ)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start_idx,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]  rotated;
  logic [IW-1:0] offset;

  // Rotate the request vector so bit 0 corresponds to start_idx.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    rotated = '0;
    for (int j = 0; j < N; j++) begin
      rotated[j] = req[IW'(wrap_idx(32'(start_idx), j, N))];
    end
  end

  // Priority-encode the lowest set bit of the rotated vector.
  always_comb begin
    found  = |rotated;
    offset = '0;
    for (int j = N - 1; j >= 0; j--) begin
      if (rotated[j]) offset = IW'(j);
    end
  end

  // Undo the rotation to recover the absolute requester index.
  always_comb begin
    idx = IW'(wrap_idx(32'(start_idx), 32'(offset), N));
  end

endmodule

// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter/sequencer sharing one N:1 data mux between requesters.
// One requester owns the mux per grant; the grant ends on its last beat, when
// it drops its request, or after MAX_HOLD accepted beats. Every release is
// followed by one IDLE cycle in which the next winner is chosen.
module mux_rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter  int N_REQ    = DEF_N_REQ,
  parameter  int DATA_W   = DEF_DATA_W,
  parameter  int MAX_HOLD = DEF_MAX_HOLD,
  localparam int SEL_W    = sel_width(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ-1:0]        last,
  input  logic [N_REQ*DATA_W-1:0] data_in,
  input  logic                    out_ready,
  output logic [N_REQ-1:0]        grant,
  output logic [SEL_W-1:0]        sel,
  output logic [DATA_W-1:0]       data_out,
  output logic                    valid_out,
  output logic                    busy
);

  localparam int               CNT_W        = $clog2(MAX_HOLD + 1);
  // The search starts at last_idx+1, so this makes the first search start at 0.
  localparam logic [SEL_W-1:0] LAST_IDX_RST = SEL_W'(N_REQ - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(MAX_HOLD - 1);

  arb_state_e        state, state_next;
  logic [N_REQ-1:0]  grant_next;
  logic [SEL_W-1:0]  sel_next;
  logic [SEL_W-1:0]  last_idx, last_idx_next;
  logic [SEL_W-1:0]  start_idx;
  logic [SEL_W-1:0]  winner;
  logic              found;
  logic [CNT_W-1:0]  hold_cnt, hold_next;
  logic              req_sel;
  logic              last_sel;
  logic              beat;
  logic              at_limit;
  rel_cause_e        rel_cause;
  logic [DATA_W-1:0] data_slice [N_REQ];

  // Unpack the flat data bus into one word per requester.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_slice
    assign data_slice[gi] = data_in[gi*DATA_W +: DATA_W];
  end

  // Next search position: one past the most recently released requester.
  always_comb begin
    start_idx = (last_idx == LAST_IDX_RST) ? '0 : last_idx + 1'b1;
  end

  rr_pick #(
    .N  (N_REQ),
    .IW (SEL_W)
  ) u_pick (
    .req       (req),
    .start_idx (start_idx),
    .found     (found),
    .idx       (winner)
  );

  // Granted-requester view and sink handshake, all from registered sel/state.
  always_comb begin
    busy      = (state == GRANT);
    req_sel   = req[sel];
    last_sel  = last[sel];
    valid_out = busy & req_sel;
    beat      = valid_out & out_ready;
    at_limit  = (hold_cnt == HOLD_LAST);
    data_out  = busy ? data_slice[sel] : '0;
  end

  // Decide whether the current grant ends this cycle; abandon wins over
  // last-beat, which wins over the hold limit.
  always_comb begin
    rel_cause = REL_NONE;
    if (state == GRANT) begin
      if (!req_sel) begin
        rel_cause = REL_ABANDON;
      end else if (beat && last_sel) begin
        rel_cause = REL_LAST;
      end else if (beat && at_limit) begin
        rel_cause = REL_LIMIT;
      end
    end
  end

  // Next-state logic: IDLE picks a winner, GRANT counts beats until release.
  always_comb begin
    state_next    = state;
    grant_next    = grant;
    sel_next      = sel;
    last_idx_next = last_idx;
    hold_next     = hold_cnt;
    case (state)
      IDLE: begin
        if (found) begin
          state_next = GRANT;
          grant_next = N_REQ'(1) << winner;
          sel_next   = winner;
          hold_next  = '0;
        end
      end
      GRANT: begin
        if (rel_cause != REL_NONE) begin
          state_next    = IDLE;
          grant_next    = '0;
          sel_next      = '0;
          last_idx_next = sel;
          hold_next     = '0;
        end else if (beat) begin
          hold_next = hold_cnt + 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        grant_next = '0;
        sel_next   = '0;
        hold_next  = '0;
      end
    endcase
  end

  // State, grant, select, round-robin pointer and hold counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: every register here, including the round-robin pointer, is reset so the first search is deterministic.
    if (!rst_n) begin
      state    <= IDLE;
      grant    <= '0;
      sel      <= '0;
      last_idx <= LAST_IDX_RST;
      hold_cnt <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state    <= state_next;
      grant    <= grant_next;
      sel      <= sel_next;
      last_idx <= last_idx_next;
      hold_cnt <= hold_next;
    end
  end

  // Structural invariants of the grant datapath.
  a_grant_onehot0 : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0(grant));
  a_grant_matches_sel : assert property (@(posedge clk) disable iff (!rst_n)
    (state == GRANT) |-> (grant == (N_REQ'(1) << sel)));
  a_idle_no_grant : assert property (@(posedge clk) disable iff (!rst_n)
    (state == IDLE) |-> (grant == '0));
  a_hold_bounded : assert property (@(posedge clk) disable iff (!rst_n)
    hold_cnt <= HOLD_LAST);

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Self-checking bench for mux_rr_arbiter (N_REQ=4, DATA_W=8, MAX_HOLD=4).
// Accepted beats are predicted into a queue when stimulus is driven and
// popped by a monitor whenever the sink accepts a beat.
module tb_mux_rr_arbiter;

  localparam int N_REQ    = 4;
  localparam int DATA_W   = 8;
  localparam int MAX_HOLD = 4;

  logic                    clk;
  logic                    rst_n;
  logic [N_REQ-1:0]        req;
  logic [N_REQ-1:0]        last;
  logic [N_REQ*DATA_W-1:0] data_in;
  logic                    out_ready;
  logic [N_REQ-1:0]        grant;
  logic [1:0]              sel;
  logic [DATA_W-1:0]       data_out;
  logic                    valid_out;
  logic                    busy;

  typedef struct {
    logic [1:0]        idx;
    logic [DATA_W-1:0] data;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_e;
  int    n_checks = 0;
  int    n_pass   = 0;

  mux_rr_arbiter #(
    .N_REQ    (N_REQ),
    .DATA_W   (DATA_W),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req),
    .last      (last),
    .data_in   (data_in),
    .out_ready (out_ready),
    .grant     (grant),
    .sel       (sel),
    .data_out  (data_out),
    .valid_out (valid_out),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard consumer: every accepted beat must match the oldest prediction.
  always @(negedge clk) begin
    if (rst_n && valid_out && out_ready) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL sb_unexpected_beat: got sel=%0d data=%h, required no beat", sel, data_out);
      end else begin
        mon_e = exp_q.pop_front();
        if ({sel, data_out} !== {mon_e.idx, mon_e.data})
          $display("FAIL sb_beat: got sel=%0d data=%h, required sel=%0d data=%h",
                   sel, data_out, mon_e.idx, mon_e.data);
        else n_pass++;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid_cycle();
    @(negedge clk);
  endtask

  task automatic set_data(input int idx, input logic [DATA_W-1:0] val);
    data_in[idx*DATA_W +: DATA_W] = val;
  endtask

  task automatic push_beat(input int idx, input logic [DATA_W-1:0] val);
    beat_t b;
    b.idx  = 2'(idx);
    b.data = val;
    exp_q.push_back(b);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0; data_in = '0;
    mid_cycle();
    #2 rst_n = 1'b1;
    next_cycle();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = 4'b1111; last = '0; out_ready = 1'b0; data_in = 32'h44332211;
    repeat (2) @(posedge clk);
    mid_cycle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_grant: got %b, required 0000", grant); else n_pass++;
    n_checks++; if (sel !== 2'd0) $display("FAIL reset_sel: got %0d, required 0", sel); else n_pass++;
    n_checks++; if (valid_out !== 1'b0) $display("FAIL reset_valid: got %b, required 0", valid_out); else n_pass++;
    n_checks++; if (data_out !== 8'h00) $display("FAIL reset_data: got %h, required 00", data_out); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b, required 0", busy); else n_pass++;
    #2 rst_n = 1'b1;
    next_cycle();
    n_checks++; if (grant !== 4'b0001) $display("FAIL reset_first_grant: got %b, required 0001", grant); else n_pass++;
    n_checks++; if (sel !== 2'd0) $display("FAIL reset_first_sel: got %0d, required 0", sel); else n_pass++;
    req = '0;
    next_cycle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL reset_abandon: got %b, required 0000", grant); else n_pass++;
  endtask

  task automatic test_rotation();
    logic [3:0] seq [9];
    seq = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
    do_reset();
    req = 4'b1111; last = 4'b1111; out_ready = 1'b1;
    data_in = {8'h13, 8'h12, 8'h11, 8'h10};
    for (int i = 0; i < 4; i++) push_beat(i, 8'(8'h10 + i));
    push_beat(0, 8'h10);
    for (int c = 0; c < 9; c++) begin
      next_cycle();
      mid_cycle();
      n_checks++;
      if (grant !== seq[c] || busy !== (seq[c] != 4'b0000))
        $display("FAIL rotation_c%0d: got grant=%b busy=%b, required grant=%b busy=%b",
                 c, grant, busy, seq[c], (seq[c] != 4'b0000));
      else n_pass++;
    end
    next_cycle();
    req = '0; last = '0;
    next_cycle();
    n_checks++; if (exp_q.size() != 0) $display("FAIL rotation_drain: got %0d pending beats, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_stall();
    do_reset();
    req = 4'b0100; out_ready = 1'b0; last = '0;
    push_beat(2, 8'hA1); push_beat(2, 8'hA2); push_beat(2, 8'hA3);
    next_cycle();
    set_data(2, 8'hA1); out_ready = 1'b1;
    mid_cycle();
    n_checks++;
    if (grant !== 4'b0100 || sel !== 2'd2 || valid_out !== 1'b1 || data_out !== 8'hA1)
      $display("FAIL stall_beat1: got grant=%b sel=%0d valid=%b data=%h, required 0100/2/1/a1", grant, sel, valid_out, data_out);
    else n_pass++;
    next_cycle();
    set_data(2, 8'hA2); out_ready = 1'b0; last = 4'b0100;
    mid_cycle();
    n_checks++;
    if (grant !== 4'b0100 || valid_out !== 1'b1 || data_out !== 8'hA2)
      $display("FAIL stall_held: got grant=%b valid=%b data=%h, required 0100/1/a2", grant, valid_out, data_out);
    else n_pass++;
    set_data(2, 8'h5A);
    #1;
    n_checks++; if (data_out !== 8'h5A) $display("FAIL stall_live_data: got %h, required 5a", data_out); else n_pass++;
    set_data(2, 8'hA2);
    next_cycle();
    out_ready = 1'b1; last = '0;
    mid_cycle();
    n_checks++;
    if (grant !== 4'b0100 || data_out !== 8'hA2)
      $display("FAIL stall_beat2: got grant=%b data=%h, required 0100/a2", grant, data_out);
    else n_pass++;
    next_cycle();
    set_data(2, 8'hA3); last = 4'b0100;
    mid_cycle();
    n_checks++;
    if (grant !== 4'b0100 || data_out !== 8'hA3)
      $display("FAIL stall_beat3: got grant=%b data=%h, required 0100/a3", grant, data_out);
    else n_pass++;
    next_cycle();
    req = '0; last = '0; out_ready = 1'b0;
    mid_cycle();
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0 || valid_out !== 1'b0 || data_out !== 8'h00)
      $display("FAIL stall_release: got grant=%b busy=%b valid=%b data=%h, required 0000/0/0/00", grant, busy, valid_out, data_out);
    else n_pass++;
    next_cycle();
    n_checks++; if (exp_q.size() != 0) $display("FAIL stall_drain: got %0d pending beats, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_forced_release();
    do_reset();
    req = 4'b0010; out_ready = 1'b1; last = '0;
    for (int b = 0; b < 4; b++) push_beat(1, 8'(8'hB0 + b));
    push_beat(3, 8'hC3);
    for (int k = 0; k < 4; k++) begin
      next_cycle();
      set_data(1, 8'(8'hB0 + k));
      if (k == 0) begin
        req = 4'b1010; last = 4'b1000; set_data(3, 8'hC3);
      end
      mid_cycle();
      n_checks++;
      if (grant !== 4'b0010) $display("FAIL forced_hold_%0d: got %b, required 0010", k, grant); else n_pass++;
    end
    next_cycle();
    mid_cycle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL forced_release: got %b, required 0000", grant); else n_pass++;
    next_cycle();
    mid_cycle();
    n_checks++;
    if (grant !== 4'b1000 || sel !== 2'd3) $display("FAIL forced_next_3: got grant=%b sel=%0d, required 1000/3", grant, sel); else n_pass++;
    next_cycle();
    req = 4'b0010; last = '0;
    mid_cycle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL forced_turnaround: got %b, required 0000", grant); else n_pass++;
    push_beat(1, 8'hB4); push_beat(1, 8'hB5);
    next_cycle();
    set_data(1, 8'hB4);
    mid_cycle();
    n_checks++; if (grant !== 4'b0010) $display("FAIL forced_regrant_1: got %b, required 0010", grant); else n_pass++;
    next_cycle();
    set_data(1, 8'hB5); last = 4'b0010;
    mid_cycle();
    n_checks++; if (grant !== 4'b0010) $display("FAIL forced_regrant_last: got %b, required 0010", grant); else n_pass++;
    next_cycle();
    req = '0; last = '0;
    mid_cycle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL forced_final_release: got %b, required 0000", grant); else n_pass++;
    next_cycle();
    n_checks++; if (exp_q.size() != 0) $display("FAIL forced_drain: got %0d pending beats, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_abandon();
    do_reset();
    req = 4'b0001; out_ready = 1'b1; last = '0;
    set_data(0, 8'hD0); push_beat(0, 8'hD0);
    next_cycle();
    mid_cycle();
    n_checks++;
    if (grant !== 4'b0001 || valid_out !== 1'b1 || data_out !== 8'hD0)
      $display("FAIL abandon_grant: got grant=%b valid=%b data=%h, required 0001/1/d0", grant, valid_out, data_out);
    else n_pass++;
    next_cycle();
    req = '0;
    mid_cycle();
    n_checks++;
    if (valid_out !== 1'b0 || grant !== 4'b0001)
      $display("FAIL abandon_drop: got valid=%b grant=%b, required 0/0001", valid_out, grant);
    else n_pass++;
    next_cycle();
    req = 4'b0101;
    mid_cycle();
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b0) $display("FAIL abandon_release: got grant=%b busy=%b, required 0000/0", grant, busy); else n_pass++;
    next_cycle();
    set_data(2, 8'hD2); last = 4'b0100; push_beat(2, 8'hD2);
    mid_cycle();
    n_checks++;
    if (grant !== 4'b0100 || sel !== 2'd2) $display("FAIL abandon_next_2: got grant=%b sel=%0d, required 0100/2", grant, sel); else n_pass++;
    next_cycle();
    req = '0; last = '0;
    mid_cycle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL abandon_final: got %b, required 0000", grant); else n_pass++;
    next_cycle();
    n_checks++; if (exp_q.size() != 0) $display("FAIL abandon_drain: got %0d pending beats, required 0", exp_q.size()); else n_pass++;
  endtask

  task automatic test_async_reset();
    do_reset();
    req = 4'b0010; out_ready = 1'b1; last = '0;
    set_data(1, 8'hE1); push_beat(1, 8'hE1);
    next_cycle();
    mid_cycle();
    n_checks++; if (grant !== 4'b0010) $display("FAIL areset_grant: got %b, required 0010", grant); else n_pass++;
    next_cycle();
    set_data(1, 8'hE2);
    #1 rst_n = 1'b0;
    #1;
    n_checks++;
    if (grant !== 4'b0000 || sel !== 2'd0 || valid_out !== 1'b0 || busy !== 1'b0 || data_out !== 8'h00)
      $display("FAIL areset_clear: got grant=%b sel=%0d valid=%b busy=%b data=%h, required 0000/0/0/0/00",
               grant, sel, valid_out, busy, data_out);
    else n_pass++;
    #1;
    rst_n = 1'b1; req = 4'b1000; last = 4'b1000;
    set_data(3, 8'hE3); push_beat(3, 8'hE3);
    next_cycle();
    mid_cycle();
    n_checks++;
    if (grant !== 4'b1000 || sel !== 2'd3 || valid_out !== 1'b1 || data_out !== 8'hE3)
      $display("FAIL areset_regrant: got grant=%b sel=%0d valid=%b data=%h, required 1000/3/1/e3", grant, sel, valid_out, data_out);
    else n_pass++;
    next_cycle();
    req = '0; last = '0;
    mid_cycle();
    n_checks++; if (grant !== 4'b0000) $display("FAIL areset_final: got %b, required 0000", grant); else n_pass++;
    next_cycle();
    n_checks++; if (exp_q.size() != 0) $display("FAIL areset_drain: got %0d pending beats, required 0", exp_q.size()); else n_pass++;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; last = '0; out_ready = 1'b0; data_in = '0;
    test_reset();
    test_rotation();
    test_stall();
    test_forced_release();
    test_abandon();
    test_async_reset();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
